// File: rtl/tmds_pkg.sv
// Shared TMDS encoder constants: symbol modes, control tokens, guard bands, TERC4 table.
// TERC4 emission is enabled in the encoder by defining TMDS_ENCODER_TERC4_EN.
package tmds_pkg;

   localparam int unsigned SYMBOL_W = 10;

   typedef enum logic [1:0] {
      MODE_VIDEO = 2'b00,
      MODE_CTRL  = 2'b01,
      MODE_TERC4 = 2'b10,
      MODE_GUARD = 2'b11
   } mode_e;

   localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_00 = 10'h354;
   localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
   localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_10 = 10'h154;
   localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

   localparam logic [SYMBOL_W-1:0] GUARD_CH02 = 10'h2CC;
   localparam logic [SYMBOL_W-1:0] GUARD_CH1  = 10'h133;

   // Index 0 is the leftmost entry.
   localparam logic [0:15][SYMBOL_W-1:0] TERC4_TABLE = {
      10'h29C, 10'h263, 10'h2E4, 10'h2E2,
      10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C6,
      10'h28E, 10'h271, 10'h163, 10'h2C3
   };

   function automatic logic [3:0] popcount(input logic [SYMBOL_W-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < SYMBOL_W; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [SYMBOL_W-1:0] ctrl_token(input logic [1:0] c);
      logic [SYMBOL_W-1:0] t;
      case (c)
         2'b00:   t = CTRL_TOKEN_00;
         2'b01:   t = CTRL_TOKEN_01;
         2'b10:   t = CTRL_TOKEN_10;
         default: t = CTRL_TOKEN_11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimizing stage: builds q_m[8:0] from a pixel byte and counts ones/zeros of q_m[7:0].
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [8:0] qm_o,
   output logic [3:0] n1_o,
   output logic [3:0] n0_o
);

   logic [3:0] n1_data;
   logic       use_xnor;

   always_comb begin
      n1_data  = popcount({2'b00, data_i});
      use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);
      qm_o     = '0;
      qm_o[0]  = data_i[0];
      for (int unsigned i = 1; i < 8; i++) begin
         qm_o[i] = use_xnor ? ~(qm_o[i-1] ^ data_i[i]) : (qm_o[i-1] ^ data_i[i]);
      end
      qm_o[8] = !use_xnor;
      n1_o    = popcount({2'b00, qm_o[7:0]});
      n0_o    = 4'd8 - n1_o;
   end

endmodule

// File: rtl/tmds_encoder.sv
// Two-stage TMDS symbol encoder with FIFO backpressure and running DC balance.
// Define TMDS_ENCODER_TERC4_EN to emit TERC4 codes for mode 10 (otherwise it encodes as control).
module tmds_encoder
   import tmds_pkg::*;
#(
   parameter int unsigned CHANNEL = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [1:0]          mode_i,
   input  logic [7:0]          data_i,
   input  logic [1:0]          ctrl_i,
   input  logic [3:0]          aux_i,
   output logic [SYMBOL_W-1:0] symbol_o,
   output logic                write_symbol_o,
   input  logic                symbol_fifo_full_i,
   output logic signed [4:0]   disparity_o
);

   localparam logic [SYMBOL_W-1:0] GUARD_CODE = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;

   logic [8:0]          qm_d;
   logic [3:0]          n1_d, n0_d;
   logic                s1_valid_q, s2_valid_q;
   logic [8:0]          qm_q;
   logic [3:0]          n1_q, n0_q;
   mode_e               mode_q;
   logic [1:0]          ctrl_q;
   logic [SYMBOL_W-1:0] symbol_q, symbol_d;
   logic signed [4:0]   cnt_q, cnt_d;
   logic                advance;

`ifdef TMDS_ENCODER_TERC4_EN
   logic [3:0]          aux_q;
`else
   logic                unused_aux;
   assign unused_aux = ^aux_i;
`endif

   tmds_qm_stage u_qm (
      .data_i (data_i),
      .qm_o   (qm_d),
      .n1_o   (n1_d),
      .n0_o   (n0_d)
   );

   assign advance        = !(s2_valid_q && symbol_fifo_full_i);
   assign ready_o        = advance;
   assign write_symbol_o = s2_valid_q && !symbol_fifo_full_i;
   assign symbol_o       = symbol_q;
   assign disparity_o    = cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         qm_q       <= '0;
         n1_q       <= '0;
         n0_q       <= '0;
         mode_q     <= MODE_VIDEO;
         ctrl_q     <= '0;
         symbol_q   <= '0;
         cnt_q      <= '0;
`ifdef TMDS_ENCODER_TERC4_EN
         aux_q      <= '0;
`endif
      end else if (advance) begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            n0_q   <= n0_d;
            mode_q <= mode_e'(mode_i);
            ctrl_q <= ctrl_i;
`ifdef TMDS_ENCODER_TERC4_EN
            aux_q  <= aux_i;
`endif
         end
         // A bubble in S1 leaves the last symbol and running disparity untouched.
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            symbol_q <= symbol_d;
            cnt_q    <= cnt_d;
         end
      end
   end

   always_comb begin
      symbol_d = symbol_q;
      cnt_d    = cnt_q;
      case (mode_q)
         MODE_VIDEO: begin
            if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
               symbol_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            end else if (((cnt_q > 5'sd0) && (n1_q > n0_q)) ||
                         ((cnt_q < 5'sd0) && (n0_q > n1_q))) begin
               symbol_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            end else begin
               symbol_d = {1'b0, qm_q[8], qm_q[7:0]};
            end
            // ones - zeros = 2*ones - 10, evaluated modulo 32
            cnt_d = cnt_q + signed'({popcount(symbol_d), 1'b0}) - 5'sd10;
         end
         MODE_CTRL: begin
            symbol_d = ctrl_token(ctrl_q);
            cnt_d    = '0;
         end
         MODE_TERC4: begin
`ifdef TMDS_ENCODER_TERC4_EN
            symbol_d = TERC4_TABLE[aux_q];
`else
            symbol_d = ctrl_token(ctrl_q);
`endif
            cnt_d    = '0;
         end
         MODE_GUARD: begin
            symbol_d = GUARD_CODE;
            cnt_d    = '0;
         end
         default: begin
            symbol_d = symbol_q;
            cnt_d    = cnt_q;
         end
      endcase
   end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: channel-0 and channel-1 instances share stimulus.
module tb_tmds_encoder;

   typedef struct {
      logic [9:0] sym0;
      logic [9:0] sym1;
      logic [4:0] disp;
      int         acc;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       valid_i;
   logic [1:0] mode_i;
   logic [7:0] data_i;
   logic [1:0] ctrl_i;
   logic [3:0] aux_i;
   logic       symbol_fifo_full_i;
   logic       ready_o, write_symbol_o, ready1, write1;
   logic [9:0] symbol_o, symbol1;
   logic [4:0] disparity_o, disparity1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   model_cnt = 0;
   exp_t sb[$];

   always #5 clk_i = ~clk_i;

   tmds_encoder #(.CHANNEL(0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .mode_i(mode_i), .data_i(data_i), .ctrl_i(ctrl_i), .aux_i(aux_i),
      .symbol_o(symbol_o), .write_symbol_o(write_symbol_o),
      .symbol_fifo_full_i(symbol_fifo_full_i), .disparity_o(disparity_o)
   );

   tmds_encoder #(.CHANNEL(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready1),
      .mode_i(mode_i), .data_i(data_i), .ctrl_i(ctrl_i), .aux_i(aux_i),
      .symbol_o(symbol1), .write_symbol_o(write1),
      .symbol_fifo_full_i(symbol_fifo_full_i), .disparity_o(disparity1)
   );

   function automatic logic [9:0] model_ctrl(input logic [1:0] c);
      case (c)
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   function automatic logic [9:0] model_terc4(input logic [3:0] a);
      logic [9:0] t [16];
      t = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
            10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
      return t[a];
   endfunction

   // DVI reference formulation, disparity update expressed through q_m[8]
   function automatic logic [9:0] model_video(input logic [7:0] d);
      int         n1d, n1, n0;
      logic [8:0] qm;
      logic       x;
      logic [9:0] s;
      n1d   = $countones(d);
      x     = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~x;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (model_cnt == 0 || n1 == n0) begin
         s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         model_cnt += (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         model_cnt += -(qm[8] ? 0 : 2) + n1 - n0;
      end
      return s;
   endfunction

   task automatic push(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                       input logic [3:0] a);
      exp_t e;
      e.acc = cyc;
      case (m)
         2'b00: begin e.sym0 = model_video(d); e.sym1 = e.sym0; end
         2'b01: begin e.sym0 = model_ctrl(c); e.sym1 = e.sym0; model_cnt = 0; end
`ifdef TMDS_ENCODER_TERC4_EN
         2'b10: begin e.sym0 = model_terc4(a); e.sym1 = e.sym0; model_cnt = 0; end
`else
         2'b10: begin e.sym0 = model_ctrl(c); e.sym1 = e.sym0; model_cnt = 0; end
`endif
         default: begin e.sym0 = 10'h2CC; e.sym1 = 10'h133; model_cnt = 0; end
      endcase
      e.disp = 5'(model_cnt);
      sb.push_back(e);
   endtask

   // Called at a falling edge: apply inputs, settle, record an acceptance.
   task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d,
                        input logic [1:0] c, input logic [3:0] a, input logic f);
      valid_i = v; mode_i = m; data_i = d; ctrl_i = c; aux_i = a;
      symbol_fifo_full_i = f;
      #1;
      if (v && ready_o) push(m, d, c, a);
   endtask

   task automatic tick();
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      sb.delete();
      model_cnt = 0;
      drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b1);
      tick();
      drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b1);
      n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
      n_cmp++; if (write_symbol_o !== 1'b0) begin n_bad++; $display("FAIL reset_write got=%b exp=0", write_symbol_o); end
      n_cmp++; if (symbol_o !== 10'h000) begin n_bad++; $display("FAIL reset_symbol got=%h exp=000", symbol_o); end
      n_cmp++; if (disparity_o !== 5'd0) begin n_bad++; $display("FAIL reset_disparity got=%0d exp=0", $signed(disparity_o)); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_video_zero();
      logic [9:0] lit_sym [2];
      logic [4:0] lit_disp [2];
      int         k;
      exp_t       e;
      lit_sym  = '{10'h100, 10'h3FF};
      lit_disp = '{5'h18, 5'h02};
      k = 0;
      for (int c = 0; c < 6; c++) begin
         drive(c < 2, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL zero_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL zero_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL zero_disp got=%h exp=%h", disparity_o, e.disp); end
               n_cmp++; if (cyc - e.acc !== 2) begin n_bad++; $display("FAIL zero_latency got=%0d exp=2", cyc - e.acc); end
               if (k < 2) begin
                  n_cmp++; if (symbol_o !== lit_sym[k]) begin n_bad++; $display("FAIL zero_literal_sym got=%h exp=%h", symbol_o, lit_sym[k]); end
                  n_cmp++; if (disparity_o !== lit_disp[k]) begin n_bad++; $display("FAIL zero_literal_disp got=%h exp=%h", disparity_o, lit_disp[k]); end
               end
            end
            k++;
         end
         tick();
      end
      n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL zero_write_count got=%0d exp=2", k); end
   endtask

   task automatic test_control();
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) drive(1'b1, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         else if (c < 5) drive(1'b1, 2'b01, 8'hA5, 2'(c - 1), 4'h0, 1'b0);
         else drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL ctrl_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL ctrl_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL ctrl_disp got=%h exp=%h", disparity_o, e.disp); end
            end
         end
         tick();
      end
      n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL ctrl_pending got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_guard();
      exp_t e;
      for (int c = 0; c < 6; c++) begin
         if (c == 0) drive(1'b1, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         else if (c < 3) drive(1'b1, 2'b11, 8'h00, 2'b00, 4'h0, 1'b0);
         else drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL guard_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL guard_ch0 got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL guard_disp0 got=%h exp=%h", disparity_o, e.disp); end
               n_cmp++; if (write1 !== 1'b1) begin n_bad++; $display("FAIL guard_write1 got=%b exp=1", write1); end
               n_cmp++; if (symbol1 !== e.sym1) begin n_bad++; $display("FAIL guard_ch1 got=%h exp=%h", symbol1, e.sym1); end
               n_cmp++; if (disparity1 !== e.disp) begin n_bad++; $display("FAIL guard_disp1 got=%h exp=%h", disparity1, e.disp); end
            end
         end
         tick();
      end
      n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL guard_pending got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_stall();
      logic [7:0] wv [3];
      logic [9:0] stall_sym;
      logic       f;
      int         idx;
      exp_t       e;
      wv = '{8'h10, 8'h20, 8'h30};
      idx = 0;
      stall_sym = '0;
      for (int c = 0; c < 12; c++) begin
         f = (c >= 2 && c <= 4);
         drive(idx < 3, 2'b00, (idx < 3) ? wv[idx] : 8'h00, 2'b00, 4'h0, f);
         if (f) begin
            n_cmp++; if (write_symbol_o !== 1'b0) begin n_bad++; $display("FAIL stall_write got=%b exp=0", write_symbol_o); end
            n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_ready got=%b exp=0", ready_o); end
            if (c == 2) stall_sym = symbol_o;
            else begin
               n_cmp++; if (symbol_o !== stall_sym) begin n_bad++; $display("FAIL stall_symbol_hold got=%h exp=%h", symbol_o, stall_sym); end
            end
         end
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL stall_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL stall_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL stall_disp got=%h exp=%h", disparity_o, e.disp); end
            end
         end
         if (valid_i && ready_o) idx++;
         tick();
      end
      n_cmp++; if (idx !== 3 || sb.size() !== 0) begin n_bad++; $display("FAIL stall_drain accepted=%0d pending=%0d exp=3/0", idx, sb.size()); end
   endtask

   task automatic test_reset_midstream();
      logic [7:0] wv [3];
      logic       first;
      exp_t       e;
      drive(1'b1, 2'b00, 8'h40, 2'b00, 4'h0, 1'b0); tick();
      drive(1'b1, 2'b00, 8'h50, 2'b00, 4'h0, 1'b0); tick();
      rst_i = 1'b1;
      sb.delete();
      model_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         n_cmp++; if (write_symbol_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_write got=%b exp=0", write_symbol_o); end
         n_cmp++; if (disparity_o !== 5'd0) begin n_bad++; $display("FAIL rstmid_disp got=%h exp=0", disparity_o); end
         tick();
      end
      rst_i = 1'b0;
      wv = '{8'h00, 8'h60, 8'h70};
      first = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drive(c < 3, 2'b00, (c < 3) ? wv[c] : 8'h00, 2'b00, 4'h0, 1'b0);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL rstmid_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL rstmid_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL rstmid_disp_after got=%h exp=%h", disparity_o, e.disp); end
            end
            if (first) begin
               n_cmp++; if (symbol_o !== 10'h100) begin n_bad++; $display("FAIL rstmid_first got=%h exp=100", symbol_o); end
               first = 1'b0;
            end
         end
         tick();
      end
      n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL rstmid_pending got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_terc4();
      logic [9:0] lit [2];
      int         k;
      exp_t       e;
`ifdef TMDS_ENCODER_TERC4_EN
      lit = '{10'h29C, 10'h2C3};
`else
      lit = '{10'h354, 10'h354};
`endif
      k = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 0) drive(1'b1, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         else if (c == 1) drive(1'b1, 2'b10, 8'h00, 2'b00, 4'h0, 1'b0);
         else if (c == 2) drive(1'b1, 2'b10, 8'h00, 2'b00, 4'hF, 1'b0);
         else drive(1'b0, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL terc4_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL terc4_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL terc4_disp got=%h exp=%h", disparity_o, e.disp); end
            end
            if (k >= 1 && k <= 2) begin
               n_cmp++; if (symbol_o !== lit[k-1]) begin n_bad++; $display("FAIL terc4_literal got=%h exp=%h", symbol_o, lit[k-1]); end
            end
            k++;
         end
         tick();
      end
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL terc4_write_count got=%0d exp=3", k); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] m;
      logic [7:0] d;
      logic [1:0] c2;
      logic [3:0] a;
      logic       v, f;
      int         sent;
      exp_t       e;
      sent = 0;
      m = 2'b00; d = 8'h00; c2 = 2'b00; a = 4'h0;
      for (int c = 0; c < 400; c++) begin
         if (sent >= 40 && sb.size() == 0) break;
         v = (sent < 40) && ($urandom_range(0, 9) < 8);
         f = ($urandom_range(0, 9) < 3);
         drive(v, m, d, c2, a, f);
         if (write_symbol_o) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_extra_write symbol=%h", symbol_o); end
            else begin
               e = sb.pop_front();
               if (symbol_o !== e.sym0) begin n_bad++; $display("FAIL b2b_symbol got=%h exp=%h", symbol_o, e.sym0); end
               n_cmp++; if (disparity_o !== e.disp) begin n_bad++; $display("FAIL b2b_disp got=%h exp=%h", disparity_o, e.disp); end
            end
         end
         if (v && ready_o) begin
            sent++;
            m  = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            d  = 8'($urandom);
            c2 = 2'($urandom);
            a  = 4'($urandom);
         end
         tick();
      end
      n_cmp++; if (sent !== 40 || sb.size() !== 0) begin n_bad++; $display("FAIL b2b_timeout sent=%0d pending=%0d exp=40/0", sent, sb.size()); end
   endtask

   initial begin
      rst_i = 1'b1;
      valid_i = 1'b0; mode_i = '0; data_i = '0; ctrl_i = '0; aux_i = '0;
      symbol_fifo_full_i = 1'b0;
      @(negedge clk_i);
      test_reset();
      test_video_zero();
      test_control();
      test_guard();
      test_stall();
      test_reset_midstream();
      test_terc4();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have parameter CHANNEL, default 0, TMDS lane index (0..2) that selects the guard-band code.
REQ-002 The block SHALL have port clk_i, input, 1 bit: pixel-logic clock, the same clock as the serializer write clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port valid_i, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port ready_o, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 The block SHALL have port mode_i, input, 2 bits: symbol type, 00 video, 01 control, 10 TERC4, 11 guard band.
REQ-007 The block SHALL have port data_i, input, 8 bits: video pixel component.
REQ-008 The block SHALL have port ctrl_i, input, 2 bits: control bits {C1,C0}.
REQ-009 The block SHALL have port aux_i, input, 4 bits: TERC4 nibble.
REQ-010 The block SHALL have port symbol_o, output, 10 bits: encoded symbol, bit 0 transmitted first.
REQ-011 The block SHALL have port write_symbol_o, output, 1 bit: write strobe to the serializer FIFO.
REQ-012 The block SHALL have port symbol_fifo_full_i, input, 1 bit: serializer FIFO full flag.
REQ-013 The block SHALL have port disparity_o, output, 5 bits signed: running disparity after the last written symbol.

Function
REQ-014 The block SHALL be a 2-stage pipeline. S1 registers q_m[8:0], N1/N0 of q_m[7:0], and mode/ctrl/aux; S2 registers symbol_o and the updated disparity.
REQ-015 Advance SHALL be defined as !(out_valid && symbol_fifo_full_i). ready_o SHALL equal advance, combinationally. On a stall, S1, S2 and the disparity SHALL all hold.
REQ-016 write_symbol_o SHALL equal out_valid && !symbol_fifo_full_i, so there are no writes while full. Each accepted word SHALL be written exactly once, in order.
REQ-017 Latency SHALL be 2 clk_i cycles from valid_i&&ready_o to the matching symbol_o/out_valid, absent stalls. Throughput SHALL be 1 word per cycle.
REQ-018 S1 video encoding SHALL use XNOR when (N1(data_i)>4) || (N1==4 && data_i[0]==0), and XOR otherwise. q_m[8] SHALL be 1 for XOR and 0 for XNOR.
REQ-019 S2 video encoding SHALL follow the DVI 1.0 DC-balance rules:
- If cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
- Else, if (cnt>0 && N1>N0) || (cnt<0 && N0>N1): invert, out = {1, q_m[8], ~q_m[7:0]}.
- Else: out = {0, q_m[8], q_m[7:0]}.
REQ-020 After each video symbol, cnt SHALL equal the old cnt plus (ones − zeros) of the 10-bit output. The arithmetic SHALL be 5-bit signed, with range −10..+10 and no saturation needed.
REQ-021 Control tokens SHALL be: 00→0x354, 01→0x0AB, 10→0x154, 11→0x2AB. A control symbol SHALL clear cnt to 0.
REQ-022 Guard band SHALL be 0x2CC for CHANNEL 0 and 2, and 0x133 for CHANNEL 1. A guard-band symbol SHALL clear cnt to 0.
REQ-023 Bubbles (valid_i low while advancing) SHALL clear the stage valid bits, leave cnt unchanged, and produce no write.

Reset
REQ-024 While rst_i is high, the block SHALL drive: S1/S2 valid bits 0, symbol_o 0x000, cnt 0, write_symbol_o 0, ready_o 1, disparity_o 0.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight words. The first word accepted after release SHALL be encoded with cnt=0.

Configuration
REQ-026 With macro TMDS_ENCODER_TERC4_EN defined, mode 10 SHALL emit the HDMI TERC4 code for aux_i and clear cnt. TERC4 codes by aux_i value:
- 0→0x29C, 1→0x263, 2→0x2E4, 3→0x2E2
- 4→0x171, 5→0x11E, 6→0x18E, 7→0x13C
- 8→0x2CC, 9→0x139, A→0x19C, B→0x2C6
- C→0x28E, D→0x271, E→0x163, F→0x2C3
REQ-027 Without TMDS_ENCODER_TERC4_EN, mode 10 SHALL be treated as control (REQ-021), and aux_i SHALL be unused.

Structure
REQ-028 Package tmds_pkg SHALL hold: the mode encoding constants, the four control-token constants, the two guard-band constants, the TERC4 table, and the symbol width constant (10).
REQ-029 Sub-module tmds_qm_stage SHALL implement the S1 transition-minimizing logic and ones count. The top level SHALL hold the handshake, the DC balance and cnt.

Verification
REQ-030 Video 0x00 then 0x00 from reset, FIFO never full → symbols 0x100 (disparity −8), then 0x3FF (disparity +2).
REQ-031 Control sequence ctrl 00,01,10,11 → symbols 0x354, 0x0AB, 0x154, 0x2AB, with disparity_o 0 after each.
REQ-032 Guard band with CHANNEL=1 → 0x133; with CHANNEL=0 → 0x2CC; disparity_o 0.
REQ-033 Stream 0x10,0x20,0x30; symbol_fifo_full_i high for 3 cycles while the first symbol is pending → no write, ready_o 0, symbol_o stable. On release, the three symbols are written in order and match the reference model.
REQ-034 Reset pulse after two of five words are accepted → no writes during reset. The next word 0x00 encodes as 0x100.
REQ-035 TMDS_ENCODER_TERC4_EN defined, mode 10, aux 0x0 and 0xF → 0x29C and 0x2C3. Without the macro, aux 0xF with ctrl 00 → 0x354.
